// File: rtl/pipe_ctrl_pkg.sv
// Shared opcodes, state encoding and enable bundle for the pipeline sequencer.
// Imported by pipe_hazard_sequencer and its helpers.
package pipe_ctrl_pkg;

  localparam logic [3:0] OP_ARITH = 4'b0000;
  localparam logic [3:0] OP_LBU   = 4'b1010;
  localparam logic [3:0] OP_LOAD  = 4'b1100;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [1:0] MEMREAD_NONE = 2'b00;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } seq_state_t;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic exmem_write;
  } pipe_en_t;

  localparam pipe_en_t EN_NONE = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter, cleared by asynchronous active-low reset.
// Holds at all-ones once reached.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !(&cnt_q)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_sequencer.sv
// Pipeline stall/flush/freeze sequencer with RUN -> DRAIN -> HALTED lifecycle.
// Optional perf counters enabled by defining PIPE_PERF_CNT_EN.
module pipe_hazard_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int REG_ADDR_W   = 4,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            id_opCode,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_rs_used,
  input  logic                  id_rt_used,
  input  logic [1:0]            ex_memRead,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_redirect,
  input  logic                  mem_busy,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic                  exmem_write,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  seq_state_t    state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          halted_q, halted_d;
  pipe_en_t      en;
  logic          load_use;

  assign load_use = (ex_memRead != MEMREAD_NONE)
                 && (ex_rd != '0)
                 && ((id_rs_used && id_rs == ex_rd)
                  || (id_rt_used && id_rt == ex_rd));

  always_comb begin
    en      = EN_NONE;
    state_d = state_q;
    drain_d = drain_q;
    unique case (state_q)
      RUN: begin
        if (mem_busy) begin
          en = EN_NONE;
        end else if (ex_redirect) begin
          en = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        end else if (load_use) begin
          en = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        end else if (id_opCode == OP_HALT) begin
          en      = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
          state_d = DRAIN;
          drain_d = DW'(DRAIN_CYCLES);
        end else begin
          en = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        end
      end
      DRAIN: begin
        en = '{1'b0, 1'b0, 1'b0, 1'b1, !mem_busy};
        if (!mem_busy) begin
          if (drain_q == DW'(1)) begin
            state_d = HALTED;
          end else begin
            drain_d = drain_q - DW'(1);
          end
        end
      end
      HALTED: en = EN_NONE;
      default: state_d = RUN;
    endcase
    // Reset must hold the pipeline completely still.
    if (!rst_n) begin
      en = EN_NONE;
    end
    halted_d = (state_d == HALTED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      drain_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      halted_q <= halted_d;
    end
  end

  assign pc_write    = en.pc_write;
  assign ifid_write  = en.ifid_write;
  assign ifid_flush  = en.ifid_flush;
  assign idex_bubble = en.idex_bubble;
  assign exmem_write = en.exmem_write;
  assign halted      = halted_q;

`ifdef PIPE_PERF_CNT_EN
  logic stall_inc;
  logic flush_inc;

  assign stall_inc = (state_q == RUN)
                  && (mem_busy || (!ex_redirect && load_use));
  assign flush_inc = (state_q == RUN) && !mem_busy && ex_redirect;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .cnt   (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
// Bench for pipe_hazard_sequencer: directed steps then random traffic
// checked against a cycle-level behavioural model.
module tb_pipe_hazard_sequencer;

  localparam int CW   = 4;
  localparam int MAXC = 15;
`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    id_opCode;
  logic [3:0]    id_rs, id_rt, ex_rd;
  logic          id_rs_used, id_rt_used;
  logic [1:0]    ex_memRead;
  logic          ex_redirect, mem_busy;
  logic          pc_write, ifid_write, ifid_flush;
  logic          idex_bubble, exmem_write, halted;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int passes = 0;
  int checks = 0;

  // Model: 0 = running, 1 = draining, 2 = stopped.
  int m_mode  = 0;
  int m_left  = 0;
  int m_stall = 0;
  int m_flush = 0;

  pipe_hazard_sequencer #(
    .DRAIN_CYCLES (3),
    .REG_ADDR_W   (4),
    .CNT_W        (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_opCode   (id_opCode),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rs_used  (id_rs_used),
    .id_rt_used  (id_rt_used),
    .ex_memRead  (ex_memRead),
    .ex_rd       (ex_rd),
    .ex_redirect (ex_redirect),
    .mem_busy    (mem_busy),
    .pc_write    (pc_write),
    .ifid_write  (ifid_write),
    .ifid_flush  (ifid_flush),
    .idex_bubble (idex_bubble),
    .exmem_write (exmem_write),
    .halted      (halted),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_left  = 0;
    m_stall = 0;
    m_flush = 0;
  endtask

  // One cycle: drive, check against model, clock, advance model.
  task automatic step(input logic busy, input logic redir,
                      input logic [3:0] op, input logic [1:0] mr,
                      input logic [3:0] rd, input logic [3:0] rs,
                      input logic [3:0] rt, input logic rsu,
                      input logic rtu, input logic rn);
    int  exp_en;
    int  n_mode, n_left;
    bit  s_inc, f_inc, lu;
    rst_n = rn; mem_busy = busy; ex_redirect = redir;
    id_opCode = op; ex_memRead = mr; ex_rd = rd;
    id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu;
    #1;
    if (!rn) model_reset();
    n_mode = m_mode; n_left = m_left;
    s_inc = 0; f_inc = 0;
    lu = (mr != 0) && (rd != 0)
      && ((rsu && rs == rd) || (rtu && rt == rd));
    exp_en = 0;
    if (!rn) begin
      exp_en = 0;
    end else if (m_mode == 0) begin
      if (busy) begin
        exp_en = 5'b00000; s_inc = 1;
      end else if (redir) begin
        exp_en = 5'b11111; f_inc = 1;
      end else if (lu) begin
        exp_en = 5'b00011; s_inc = 1;
      end else if (op == 4'hF) begin
        exp_en = 5'b00011; n_mode = 1; n_left = 3;
      end else begin
        exp_en = 5'b11001;
      end
    end else if (m_mode == 1) begin
      exp_en = busy ? 5'b00010 : 5'b00011;
      if (!busy) begin
        if (m_left == 1) n_mode = 2;
        else n_left = m_left - 1;
      end
    end else begin
      exp_en = 0;
    end
    chk("enables", {pc_write, ifid_write, ifid_flush,
                    idex_bubble, exmem_write}, exp_en);
    chk("halted", int'(halted), (m_mode == 2) ? 1 : 0);
    chk("stall_cnt", int'(stall_cnt), m_stall);
    chk("flush_cnt", int'(flush_cnt), m_flush);
    @(posedge clk);
    if (!rn) begin
      model_reset();
    end else begin
      m_mode = n_mode; m_left = n_left;
      if (PERF && s_inc && m_stall < MAXC) m_stall++;
      if (PERF && f_inc && m_flush < MAXC) m_flush++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic busy, input logic redir,
                      input logic [3:0] op);
    step(busy, redir, op, 2'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 4'h0, 2'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; mem_busy = 1'b0; ex_redirect = 1'b0;
    id_opCode = 4'h0; ex_memRead = 2'd0; ex_rd = 4'd0;
    id_rs = 4'd0; id_rt = 4'd0; id_rs_used = 1'b0; id_rt_used = 1'b0;
    #2;
    do_reset();
    idle(1'b0, 1'b0, 4'h0);
    chk("run_after_reset", int'({pc_write, ifid_write, exmem_write}), 7);
    // Load-use, then register 0 and unused-source variants.
    step(1'b0, 1'b0, 4'h0, 2'd1, 4'd5, 4'd5, 4'd0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 4'h0, 2'd0, 4'd0, 4'd5, 4'd0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 4'h0, 2'd1, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 4'h0, 2'd1, 4'd5, 4'd5, 4'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 4'h0, 2'd2, 4'd7, 4'd1, 4'd7, 1'b0, 1'b1, 1'b1);
    // Freeze beats redirect.
    do_reset();
    idle(1'b1, 1'b1, 4'h0);
    idle(1'b0, 1'b1, 4'h0);
    chk("flush_cnt_one", int'(flush_cnt), PERF ? 1 : 0);
    chk("stall_cnt_one", int'(stall_cnt), PERF ? 1 : 0);
    // Halt drain with no waits.
    do_reset();
    idle(1'b0, 1'b0, 4'hF);
    for (int i = 0; i < 3; i++) idle(1'b0, 1'b0, 4'h0);
    chk("halt_4_edges", int'(halted), 1);
    idle(1'b0, 1'b1, 4'h0);
    // Halt drain with two busy cycles.
    do_reset();
    idle(1'b0, 1'b0, 4'hF);
    idle(1'b1, 1'b0, 4'h0);
    idle(1'b1, 1'b0, 4'h0);
    idle(1'b0, 1'b0, 4'h0);
    idle(1'b0, 1'b1, 4'h0);
    chk("not_yet_halted", int'(halted), 0);
    idle(1'b0, 1'b0, 4'h0);
    chk("halt_6_edges", int'(halted), 1);
    // Wrong-path halt discarded.
    do_reset();
    idle(1'b0, 1'b1, 4'hF);
    idle(1'b0, 1'b0, 4'h0);
    chk("wrong_path_halt", int'(halted), 0);
    // Reset in the middle of a drain.
    idle(1'b0, 1'b0, 4'hF);
    idle(1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b0, 4'h0, 2'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0, 4'h0);
    idle(1'b0, 1'b0, 4'h0);
    chk("mid_drain_reset", int'(halted), 0);
    // Saturation.
    do_reset();
    for (int i = 0; i < 20; i++) idle(1'b1, 1'b0, 4'h0);
    chk("stall_saturate", int'(stall_cnt), PERF ? MAXC : 0);
    for (int i = 0; i < 18; i++) idle(1'b0, 1'b1, 4'h0);
    chk("flush_saturate", int'(flush_cnt), PERF ? MAXC : 0);
    // Random traffic.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic        rn;
      logic [3:0]  op;
      rn = ($urandom_range(0, 99) != 0)
        && !(m_mode == 2 && $urandom_range(0, 2) == 0);
      op = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), op,
           2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
           4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rn);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
